alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Sequencer between instruction decode and the 16-bit ALU. Accepts one ALU op per request
//  handshake and drives the ALU's opcode and operand inputs. For shifts, splits large shift
//  amounts into ALU passes of at most MAX_STEP bits. Latches the final SZCV flags and hands
//  the result to register writeback through a valid/ready handshake.
// PARAMETERS
//  WIDTH     16  datapath width; must match the ALU.
//  MAX_STEP  7   largest shift amount issued per ALU pass (ALU SRA/carry valid only for 1..7).
//  SHAMT_W   4   shift-amount bits taken from req_b[SHAMT_W-1:0].
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous reset, active low
//  req_valid    in   1      request present
//  req_ready    out  1      high only in IDLE
//  req_op       in   4      ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 MOV,
//                           8 SLL, 9 SLR, 10 SRL, 11 SRA, 12 IN
//  req_a        in   WIDTH  operand 1 (to ALU in1)
//  req_b        in   WIDTH  operand 2 or shift amount (to ALU in2)
//  flush        in   1      synchronous abort of the in-flight op
//  alu_opcode   out  4      to ALU opcode
//  alu_in1      out  WIDTH  to ALU in1
//  alu_in2      out  WIDTH  to ALU in2
//  alu_result   in   WIDTH  from ALU result
//  alu_s        in   1      ALU sign flag
//  alu_z        in   1      ALU zero flag
//  alu_c        in   1      ALU carry flag
//  alu_v        in   1      ALU overflow flag
//  wb_valid     out  1      result available
//  wb_ready     in   1      writeback accepts the result
//  wb_data      out  WIDTH  final result
//  wb_en        out  1      register write permitted
//  wb_illegal   out  1      opcode was 7, 13, 14 or 15
//  flags_szcv   out  4      architectural flag register {S,Z,C,V}
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset values:
//    - req_ready=1 (reflects IDLE).
//    - alu_opcode=4'd15; alu_in1=0; alu_in2=0.
//    - wb_valid=0; wb_data=0; wb_en=0; wb_illegal=0.
//    - flags_szcv=0; busy=0. Reset returns the FSM to IDLE.
//  - FSM states: IDLE -> EXEC -> DONE -> IDLE.
//  - IDLE: on req_valid&&req_ready, capture op, acc=req_a and rem=req_b[SHAMT_W-1:0]; go to EXEC.
//    ALU outputs are held at opcode 15 with operands 0.
//  - EXEC: drive alu_opcode=op, alu_in1=acc.
//    - Non-shift op: alu_in2=req_b; one pass.
//    - Shift op (8/10/11): alu_in2=min(rem,MAX_STEP), zero-extended.
//    - Each edge: acc<=alu_result, rem<=rem-step.
//    - Stay in EXEC while rem!=0 after the update; otherwise go to DONE.
//    - rem==0 at entry still costs exactly one pass (in2=0).
//    - SLR (op 9) is always a single pass with the full req_b.
//  - DONE entry:
//    - wb_data=acc; wb_valid=1.
//    - wb_en=1 except for CMP (5) and illegal opcodes.
//    - flags_szcv<={s,z,c,v} from the FINAL pass; not updated on illegal ops.
//  - DONE: outputs hold stable while wb_ready=0. On wb_ready: wb_valid<=0, go to IDLE.
//    The next request is accepted no earlier than the following cycle.
//  - Latency: a request accepted at edge T gives wb_valid after edge T+1+N, where N = number of
//    passes. Single-pass: wb_valid visible in the cycle after T+2.
//  - Shift pass count: N = ceil(amount/MAX_STEP), minimum 1.
//  - flush: in EXEC or DONE, go to IDLE next edge; wb_valid<=0; flags unchanged.
//    flush outranks wb_ready. flush in IDLE has no effect.
//  - rst_n low at any time (including mid multi-pass): immediate reset values; the partial
//    result is discarded.
//  - Illegal ops: single pass; ALU returns 0; wb_data=0, wb_illegal=1, wb_en=0.
// CONFIGURATION
//  MULTI_PASS_SHIFT_EN
//    - Defined: shift ops 8/10/11 are split into MAX_STEP passes as above; SRA and carry are
//      exact for amounts 0..15.
//    - Undefined: every op, shifts included, takes one pass with alu_in2=req_b unmodified.
//      Result/carry for amounts >7 are whatever the ALU produces.
// TESTING
//  1. ADD a=7FFF b=0001 -> wb_data=8000, wb_en=1, SZCV=1001; wb_valid in the cycle after T+2.
//  2. CMP a=0005 b=0005 -> wb_data=0000, wb_en=0, SZCV=0100; no register write.
//  3. SRA a=8000 b=000C (EN) -> passes of 7 then 5; wb_data=FFF8, C=0; wb_valid after T+3.
//     Same stimulus without EN -> single pass, wb_data=8000.
//  4. SLL a=0001 b=000F (EN) -> passes 7,7,1 giving 0080, 4000, 8000; C=0, S=1; busy 4 cycles.
//  5. wb_ready held 0 for 3 cycles -> wb_valid/wb_data stable, req_ready=0.
//     flush asserted in cycle 2 -> IDLE next edge, wb_valid=0, flags unchanged.
//  6. rst_n pulsed low during pass 2 of test 4 -> all reset values immediately; flags_szcv=0.
//     op 7 then issued -> wb_illegal=1, wb_en=0, flags unchanged.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Sequencer between instruction decode and the 16-bit ALU: issues ALU passes, latches flags, hands result to writeback.
// Optional feature macro MULTI_PASS_SHIFT_EN: splits SLL/SRL/SRA into passes of at most MAX_STEP bits.
module alu_exec_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_STEP = 7,
  parameter int unsigned SHAMT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_s,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_en,
  output logic             wb_illegal,
  output logic [3:0]       flags_szcv,
  output logic             busy
);

`ifdef MULTI_PASS_SHIFT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_IDLE = 4'd15;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  // High once the ALU inputs for the current pass are sitting on the output registers.
  logic               issued_q, issued_d;

  logic [3:0]         alu_opcode_d;
  logic [WIDTH-1:0]   alu_in1_d, alu_in2_d, wb_data_d;
  logic               wb_valid_d, wb_en_d, wb_illegal_d;
  logic [3:0]         flags_d;

  logic               split_c, illegal_c;
  logic [SHAMT_W-1:0] step_c, rem_left_c;

  function automatic logic [SHAMT_W-1:0] step_of(input logic [SHAMT_W-1:0] r);
    return (r > SHAMT_W'(MAX_STEP)) ? SHAMT_W'(MAX_STEP) : r;
  endfunction

  assign split_c    = SPLIT_EN && ((op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA));
  assign illegal_c  = (op_q == 4'd7) || (op_q >= 4'd13);
  assign step_c     = step_of(rem_q);
  assign rem_left_c = split_c ? (rem_q - step_c) : '0;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    acc_d        = acc_q;
    b_d          = b_q;
    rem_d        = rem_q;
    issued_d     = issued_q;
    alu_opcode_d = alu_opcode;
    alu_in1_d    = alu_in1;
    alu_in2_d    = alu_in2;
    wb_valid_d   = wb_valid;
    wb_data_d    = wb_data;
    wb_en_d      = wb_en;
    wb_illegal_d = wb_illegal;
    flags_d      = flags_szcv;

    case (state_q)
      IDLE: begin
        alu_opcode_d = OP_IDLE;
        alu_in1_d    = '0;
        alu_in2_d    = '0;
        if (req_valid && req_ready) begin
          op_d     = req_op;
          acc_d    = req_a;
          b_d      = req_b;
          rem_d    = req_b[SHAMT_W-1:0];
          issued_d = 1'b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (flush) begin
          state_d      = IDLE;
          wb_valid_d   = 1'b0;
          alu_opcode_d = OP_IDLE;
          alu_in1_d    = '0;
          alu_in2_d    = '0;
        end else if (!issued_q) begin
          alu_opcode_d = op_q;
          alu_in1_d    = acc_q;
          alu_in2_d    = split_c ? WIDTH'(step_c) : b_q;
          issued_d     = 1'b1;
        end else begin
          acc_d = alu_result;
          rem_d = rem_left_c;
          if (rem_left_c != '0) begin
            // Chain the next shift pass straight from this pass's result.
            alu_in1_d = alu_result;
            alu_in2_d = WIDTH'(step_of(rem_left_c));
          end else begin
            state_d      = DONE;
            alu_opcode_d = OP_IDLE;
            alu_in1_d    = '0;
            alu_in2_d    = '0;
            wb_valid_d   = 1'b1;
            wb_data_d    = illegal_c ? '0 : alu_result;
            wb_en_d      = !illegal_c && (op_q != OP_CMP);
            wb_illegal_d = illegal_c;
            if (!illegal_c) flags_d = {alu_s, alu_z, alu_c, alu_v};
          end
        end
      end
      DONE: begin
        if (flush || wb_ready) begin
          state_d      = IDLE;
          wb_valid_d   = 1'b0;
          wb_en_d      = 1'b0;
          wb_illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      issued_q   <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      alu_opcode <= OP_IDLE;
      alu_in1    <= '0;
      alu_in2    <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_en      <= 1'b0;
      wb_illegal <= 1'b0;
      flags_szcv <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      issued_q   <= issued_d;
      req_ready  <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      alu_opcode <= alu_opcode_d;
      alu_in1    <= alu_in1_d;
      alu_in2    <= alu_in2_d;
      wb_valid   <= wb_valid_d;
      wb_data    <= wb_data_d;
      wb_en      <= wb_en_d;
      wb_illegal <= wb_illegal_d;
      flags_szcv <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl with a behavioural 16-bit ALU attached.
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, flush;
  logic [3:0]  req_op, alu_opcode, flags_szcv;
  logic [15:0] req_a, req_b, alu_in1, alu_in2, alu_result, wb_data;
  logic        alu_s, alu_z, alu_c, alu_v;
  logic        wb_valid, wb_ready, wb_en, wb_illegal, busy;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_en(wb_en),
    .wb_illegal(wb_illegal), .flags_szcv(flags_szcv), .busy(busy)
  );

  // ALU stand-in: shifts are only meaningful for 1..7, larger amounts pass in1 through.
  function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    logic        c, v;
    int          n;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    n = int'(b[3:0]);
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1, 4'd5: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6, 4'd12: r = b;
      4'd8: if (b >= 16'd1 && b <= 16'd7) begin r = a << n; c = a[16-n]; end else r = a;
      4'd9: if (b >= 16'd1 && b <= 16'd7) r = (a << n) | (a >> (16 - n)); else r = a;
      4'd10: if (b >= 16'd1 && b <= 16'd7) begin r = a >> n; c = a[n-1]; end else r = a;
      4'd11: if (b >= 16'd1 && b <= 16'd7) begin r = 16'($signed(a) >>> n); c = a[n-1]; end else r = a;
      default: r = '0;
    endcase
    return {r[15], (r == 16'h0000), c, v, r};
  endfunction

  assign {alu_s, alu_z, alu_c, alu_v, alu_result} = alu_model(alu_opcode, alu_in1, alu_in2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'hF);
    check({tag, "_alu_in"}, {alu_in1, alu_in2}, 32'h0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_wb_data"}, 32'(wb_data), 32'h0);
    check({tag, "_wb_en_ill"}, {30'd0, wb_en, wb_illegal}, 32'd0);
    check({tag, "_flags"}, 32'(flags_szcv), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called #1 after a rising edge while idle; returns edges from accept to wb_valid.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int n);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!wb_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_wb(input string tag);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    flush = 1'b0; wb_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_state("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow into sign bit
    run_op(4'd0, 16'h7FFF, 16'h0001, lat);
    check("add_lat", 32'(lat), 32'd2);
    check("add_data", 32'(wb_data), 32'h8000);
    check("add_en_ill", {30'd0, wb_en, wb_illegal}, 32'd2);
    check("add_flags", 32'(flags_szcv), 32'h9);
    check("add_busy_ready", {30'd0, busy, req_ready}, 32'd2);
    release_wb("add");

    // CMP equal: flags only
    run_op(4'd5, 16'h0005, 16'h0005, lat);
    check("cmp_lat", 32'(lat), 32'd2);
    check("cmp_data", 32'(wb_data), 32'h0000);
    check("cmp_en", 32'(wb_en), 32'd0);
    check("cmp_flags", 32'(flags_szcv), 32'h4);
    release_wb("cmp");

    // SRA by 12
    run_op(4'd11, 16'h8000, 16'h000C, lat);
`ifdef MULTI_PASS_SHIFT_EN
    check("sra_lat", 32'(lat), 32'd3);
    check("sra_data", 32'(wb_data), 32'hFFF8);
`else
    check("sra_lat", 32'(lat), 32'd2);
    check("sra_data", 32'(wb_data), 32'h8000);
`endif
    check("sra_flags", 32'(flags_szcv), 32'h8);
    release_wb("sra");

    // SLL by 15
    run_op(4'd8, 16'h0001, 16'h000F, lat);
`ifdef MULTI_PASS_SHIFT_EN
    check("sll_lat", 32'(lat), 32'd4);
    check("sll_data", 32'(wb_data), 32'h8000);
    check("sll_flags", 32'(flags_szcv), 32'h8);
`else
    check("sll_lat", 32'(lat), 32'd2);
    check("sll_data", 32'(wb_data), 32'h0001);
    check("sll_flags", 32'(flags_szcv), 32'h0);
`endif
    release_wb("sll");

    // Writeback stall then flush together with wb_ready
    run_op(4'd3, 16'h8000, 16'h0001, lat);
    check("or_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(wb_valid), 32'd1);
      check("stall_data", 32'(wb_data), 32'h8001);
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    flush = 1'b1; wb_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; wb_ready = 1'b0;
    check("flushd_valid", 32'(wb_valid), 32'd0);
    check("flushd_idle", {30'd0, busy, req_ready}, 32'd1);
    check("flushd_flags", 32'(flags_szcv), 32'h8);

    // Flush during EXEC leaves flags alone
    req_op = 4'd1; req_a = 16'h0000; req_b = 16'h0001; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    check("flushx_busy_pre", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushx_idle", {30'd0, busy, req_ready}, 32'd1);
    check("flushx_valid", 32'(wb_valid), 32'd0);
    check("flushx_flags", 32'(flags_szcv), 32'h8);
    check("flushx_alu", 32'(alu_opcode), 32'hF);

    // Flush while idle has no effect
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushi_idle", {30'd0, busy, req_ready}, 32'd1);

    // SUB with borrow
    run_op(4'd1, 16'h0000, 16'h0001, lat);
    check("sub_lat", 32'(lat), 32'd2);
    check("sub_data", 32'(wb_data), 32'hFFFF);
    check("sub_flags", 32'(flags_szcv), 32'hA);
    release_wb("sub");

    // Asynchronous reset in the middle of a shift
    req_op = 4'd8; req_a = 16'h0001; req_b = 16'h000F; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Illegal opcode
    run_op(4'd7, 16'h1234, 16'h5678, lat);
    check("ill_lat", 32'(lat), 32'd2);
    check("ill_data", 32'(wb_data), 32'h0000);
    check("ill_en_ill", {30'd0, wb_en, wb_illegal}, 32'd1);
    check("ill_flags", 32'(flags_szcv), 32'h0);
    release_wb("ill");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
